// File: rtl/wb_arb_pkg.sv
// Shared constants and record types for the writeback port arbiter.
package wb_arb_pkg;

    localparam int NUM_WPORTS = 4;
    localparam int WB_AW      = 6;
    localparam int WB_DW      = 64;

    localparam logic [WB_AW-1:0] HILO_ADDR = 6'd32;
    localparam logic [WB_AW-1:0] ZERO_ADDR = 6'd0;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_port_t;

endpackage

// File: rtl/rr_mask_pick.sv
// Rotating first-set finder: the lowest set bit of req_i at or after ptr_i, wrapping modulo N.
// Purely combinational; returns a one-hot mask and the matching index.
module rr_mask_pick #(
    parameter int N  = 6,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o
);

    int j;

    always_comb begin
        found_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        j        = 0;
        // Walk the rotation backwards so the last hit is the first in order.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                found_o     = 1'b1;
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter granting up to four register-file writes per cycle from NUM_REQ writeback sources.
// Optional WB_ARB_PERF_EN adds per-port write counters and a stall-cycle counter.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_WPORTS-1:0]   we,
    output logic [NUM_WPORTS*AW-1:0] waddr,
    output logic [NUM_WPORTS*DW-1:0] wdata
`ifdef WB_ARB_PERF_EN
    ,
    output logic [NUM_WPORTS*32-1:0] perf_wr_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DW-1:0] GPR_MASK = DW'(32'hFFFF_FFFF);

    wb_req_t              req_s [NUM_REQ];
    logic [NUM_REQ-1:0]   cand;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    wb_port_t             port_q [NUM_WPORTS];
    wb_port_t             port_d [NUM_WPORTS];
    logic [NUM_WPORTS-1:0] pick_found;
    logic [PW-1:0]        pick_idx [NUM_WPORTS];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_s[i].addr = req_addr[i*AW +: AW];
            req_s[i].data = req_data[i*DW +: DW];
            cand[i]       = req_valid[i] && (req_addr[i*AW +: AW] != ZERO_ADDR);
        end
    end

    // Each stage excludes earlier picks and any request sharing an address with
    // them; this also limits HI/LO to a single grant since they share addr 32.
    for (genvar s = 0; s < NUM_WPORTS; s++) begin : g_stage
        logic [NUM_REQ-1:0] taken;
        logic [NUM_REQ-1:0] elig;
        logic [NUM_REQ-1:0] oh;
        logic [NUM_REQ-1:0] taken_out;
        logic               found;
        logic [PW-1:0]      idx;

        if (s == 0) begin : g_first
            assign taken = '0;
        end else begin : g_next
            assign taken = g_stage[s-1].taken_out;
        end

        always_comb begin
            elig = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                elig[i] = cand[i] & ~taken[i];
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (taken[k] && (req_s[k].addr == req_s[i].addr)) begin
                        elig[i] = 1'b0;
                    end
                end
            end
        end

        rr_mask_pick #(
            .N  (NUM_REQ),
            .PW (PW)
        ) u_pick (
            .req_i    (elig),
            .ptr_i    (rr_ptr_q),
            .found_o  (found),
            .onehot_o (oh),
            .idx_o    (idx)
        );

        assign taken_out     = taken | (found ? oh : '0);
        assign pick_found[s] = found;
        assign pick_idx[s]   = idx;
    end

    int gcnt;
    int p;

    always_comb begin
        for (int q = 0; q < NUM_WPORTS; q++) begin
            port_d[q]    = port_q[q];
            port_d[q].we = 1'b0;
        end
        req_ready = '0;
        rr_ptr_d  = rr_ptr_q;
        gcnt      = 0;
        p         = 0;
        if (!rst && !flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (req_s[i].addr == ZERO_ADDR)) begin
                    req_ready[i] = 1'b1;
                end
            end
            // GPR grants fill ports 1,2,3 and fall back to port 0 last.
            for (int s = 0; s < NUM_WPORTS; s++) begin
                if (pick_found[s]) begin
                    req_ready[pick_idx[s]] = 1'b1;
                    if (req_s[pick_idx[s]].addr == HILO_ADDR) begin
                        p = 0;
                    end else begin
                        p    = (gcnt == NUM_WPORTS - 1) ? 0 : gcnt + 1;
                        gcnt = gcnt + 1;
                    end
                    port_d[p].we   = 1'b1;
                    port_d[p].addr = req_s[pick_idx[s]].addr;
                    port_d[p].data = (p == 0) ? req_s[pick_idx[s]].data
                                              : (req_s[pick_idx[s]].data & GPR_MASK);
                    rr_ptr_d = (pick_idx[s] == PW'(NUM_REQ - 1)) ? '0 : pick_idx[s] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int q = 0; q < NUM_WPORTS; q++) begin
                port_q[q] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int q = 0; q < NUM_WPORTS; q++) begin
                port_q[q] <= port_d[q];
            end
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_WPORTS; q++) begin
            we[q]               = port_q[q].we;
            waddr[q*AW +: AW]   = port_q[q].addr;
            wdata[q*DW +: DW]   = port_q[q].data;
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_wr_q [NUM_WPORTS];
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            for (int q = 0; q < NUM_WPORTS; q++) begin
                perf_wr_q[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_WPORTS; q++) begin
                if (port_q[q].we) begin
                    perf_wr_q[q] <= perf_wr_q[q] + 32'd1;
                end
            end
            if (!flush && |(req_valid & ~req_ready)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_WPORTS; q++) begin
            perf_wr_cnt[q*32 +: 32] = perf_wr_q[q];
        end
    end
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, rotation, HI/LO steering, collisions, zero-address and flush.
module tb_wb_port_arbiter;

    localparam int NR = 6;
    localparam int AW = 6;
    localparam int DW = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [NR-1:0]       req_valid;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*DW-1:0]    req_data;
    logic [NR-1:0]       req_ready;
    logic [3:0]          we;
    logic [4*AW-1:0]     waddr;
    logic [4*DW-1:0]     wdata;
`ifdef WB_ARB_PERF_EN
    logic [4*32-1:0]     perf_wr_cnt;
    logic [31:0]         perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        clear_reqs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_seq();
        for (int i = 0; i < NR; i++) begin
            set_req(i, AW'(i + 1), {32'hF0F0_F0F0, 32'h0000_0100 + 32'(i)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        load_seq();
        #1;
        total++; if (req_ready !== 6'b000000) begin bad++; $display("FAIL rst_ready got=%b exp=%b", req_ready, 6'b000000); end
        step();
        total++; if (we !== 4'b0000) begin bad++; $display("FAIL rst_we got=%b exp=%b", we, 4'b0000); end
        total++; if (waddr !== '0 || wdata !== '0) begin bad++; $display("FAIL rst_wbus got=%h/%h exp=0/0", waddr, wdata); end
        step();
        total++; if (req_ready !== 6'b000000) begin bad++; $display("FAIL rst_ready2 got=%b exp=%b", req_ready, 6'b000000); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 6'b001111) begin bad++; $display("FAIL rst_first got=%b exp=%b", req_ready, 6'b001111); end
        step();
        req_valid = 6'b110000;
        total++; if (we !== 4'b1111) begin bad++; $display("FAIL rst_first_we got=%b exp=%b", we, 4'b1111); end
        // Mid-operation reset: pending requests are dropped, registered writes cleared.
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 6'b000000) begin bad++; $display("FAIL midrst_ready got=%b exp=%b", req_ready, 6'b000000); end
        step();
        total++; if (we !== 4'b0000) begin bad++; $display("FAIL midrst_we got=%b exp=%b", we, 4'b0000); end
        rst = 1'b0;
        clear_reqs();
    endtask

    task automatic test_round_robin();
        do_reset();
        load_seq();
        #1;
        total++; if (req_ready !== 6'b001111) begin bad++; $display("FAIL rr_ready0 got=%b exp=%b", req_ready, 6'b001111); end
        step();
        req_valid = 6'b110000;
        total++; if (we !== 4'b1111) begin bad++; $display("FAIL rr_we0 got=%b exp=%b", we, 4'b1111); end
        total++; if (waddr !== {6'd3, 6'd2, 6'd1, 6'd4}) begin bad++; $display("FAIL rr_waddr0 got=%h exp=%h", waddr, {6'd3, 6'd2, 6'd1, 6'd4}); end
        total++;
        if (wdata !== {64'h0000_0000_0000_0102, 64'h0000_0000_0000_0101, 64'h0000_0000_0000_0100, 64'hF0F0_F0F0_0000_0103}) begin
            bad++; $display("FAIL rr_wdata0 got=%h", wdata);
        end
        #1;
        total++; if (req_ready !== 6'b110000) begin bad++; $display("FAIL rr_ready1 got=%b exp=%b", req_ready, 6'b110000); end
        step();
        req_valid = '0;
        total++; if (we !== 4'b0110) begin bad++; $display("FAIL rr_we1 got=%b exp=%b", we, 4'b0110); end
        total++; if (waddr !== {6'd3, 6'd6, 6'd5, 6'd4}) begin bad++; $display("FAIL rr_waddr1 got=%h exp=%h", waddr, {6'd3, 6'd6, 6'd5, 6'd4}); end
        total++; if (wdata[127:64] !== 64'h0000_0000_0000_0104) begin bad++; $display("FAIL rr_wdata1 got=%h exp=%h", wdata[127:64], 64'h104); end
        // Pointer wrapped to 0: a full request set grants 0..3 again.
        load_seq();
        #1;
        total++; if (req_ready !== 6'b001111) begin bad++; $display("FAIL rr_wrap got=%b exp=%b", req_ready, 6'b001111); end
        step();
        clear_reqs();
        step();
        total++; if (we !== 4'b0000) begin bad++; $display("FAIL rr_idle got=%b exp=%b", we, 4'b0000); end
    endtask

    task automatic test_hilo();
        do_reset();
        set_req(1, 6'd32, 64'hDEAD_BEEF_0000_0001);
        set_req(3, 6'd32, 64'h1234_5678_9ABC_DEF0);
        #1;
        total++; if (req_ready !== 6'b000010) begin bad++; $display("FAIL hilo_ready0 got=%b exp=%b", req_ready, 6'b000010); end
        step();
        req_valid[1] = 1'b0;
        total++; if (we !== 4'b0001) begin bad++; $display("FAIL hilo_we0 got=%b exp=%b", we, 4'b0001); end
        total++; if (waddr[5:0] !== 6'd32 || wdata[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
            bad++; $display("FAIL hilo_port0a got=%h/%h exp=20/deadbeef00000001", waddr[5:0], wdata[63:0]);
        end
        #1;
        total++; if (req_ready !== 6'b001000) begin bad++; $display("FAIL hilo_ready1 got=%b exp=%b", req_ready, 6'b001000); end
        step();
        clear_reqs();
        total++; if (we !== 4'b0001 || wdata[63:0] !== 64'h1234_5678_9ABC_DEF0) begin
            bad++; $display("FAIL hilo_port0b got=%b/%h exp=0001/123456789abcdef0", we, wdata[63:0]);
        end
        // HI/LO takes port 0 so four GPRs cannot all fit: the fourth waits.
        do_reset();
        set_req(0, 6'd32, 64'h0000_0000_0000_00C0);
        for (int i = 1; i <= 4; i++) set_req(i, AW'(i), 64'(i));
        #1;
        total++; if (req_ready !== 6'b001111) begin bad++; $display("FAIL hilo_mix_ready got=%b exp=%b", req_ready, 6'b001111); end
        step();
        req_valid = 6'b010000;
        total++; if (waddr !== {6'd3, 6'd2, 6'd1, 6'd32} || we !== 4'b1111) begin
            bad++; $display("FAIL hilo_mix_ports got=%h we=%b exp=%h we=1111", waddr, we, {6'd3, 6'd2, 6'd1, 6'd32});
        end
        #1;
        total++; if (req_ready !== 6'b010000) begin bad++; $display("FAIL hilo_mix_left got=%b exp=%b", req_ready, 6'b010000); end
        step();
        clear_reqs();
    endtask

    task automatic test_collision();
        do_reset();
        set_req(0, 6'd5, 64'h0000_0000_0000_00AA);
        set_req(2, 6'd5, 64'h0000_0000_0000_00BB);
        #1;
        total++; if (req_ready !== 6'b000001) begin bad++; $display("FAIL col_ready0 got=%b exp=%b", req_ready, 6'b000001); end
        step();
        req_valid[0] = 1'b0;
        total++; if (we !== 4'b0010 || waddr[11:6] !== 6'd5 || wdata[127:64] !== 64'hAA) begin
            bad++; $display("FAIL col_first got=%b/%h/%h exp=0010/05/aa", we, waddr[11:6], wdata[127:64]);
        end
        #1;
        total++; if (req_ready !== 6'b000100) begin bad++; $display("FAIL col_ready1 got=%b exp=%b", req_ready, 6'b000100); end
        step();
        clear_reqs();
        total++; if (we !== 4'b0010 || wdata[127:64] !== 64'hBB) begin
            bad++; $display("FAIL col_second got=%b/%h exp=0010/bb", we, wdata[127:64]);
        end
    endtask

    task automatic test_zero_flush();
        do_reset();
        set_req(4, 6'd0, 64'h55);
        #1;
        total++; if (req_ready !== 6'b010000) begin bad++; $display("FAIL zero_ready got=%b exp=%b", req_ready, 6'b010000); end
        step();
        clear_reqs();
        total++; if (we !== 4'b0000) begin bad++; $display("FAIL zero_we got=%b exp=%b", we, 4'b0000); end
        set_req(0, 6'd7, 64'h77);
        step();
        // Registered write still completes while flush suppresses new grants.
        flush = 1'b1;
        load_seq();
        #1;
        total++; if (req_ready !== 6'b000000) begin bad++; $display("FAIL flush_ready got=%b exp=%b", req_ready, 6'b000000); end
        total++; if (we !== 4'b0010) begin bad++; $display("FAIL flush_inflight got=%b exp=%b", we, 4'b0010); end
        step();
        total++; if (we !== 4'b0000) begin bad++; $display("FAIL flush_we got=%b exp=%b", we, 4'b0000); end
        flush = 1'b0;
        #1;
        total++; if (req_ready !== 6'b011110) begin bad++; $display("FAIL flush_ptr got=%b exp=%b", req_ready, 6'b011110); end
        step();
        clear_reqs();
        step();
    endtask

`ifdef WB_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            clear_reqs();
            set_req(0, 6'd7, 64'(n));
            step();
        end
        for (int n = 0; n < 3; n++) begin
            clear_reqs();
            set_req(2 * n, 6'd9, 64'h1);
            set_req(2 * n + 1, 6'd9, 64'h2);
            step();
            req_valid[2 * n] = 1'b0;
            step();
        end
        clear_reqs();
        step();
        step();
        total++; if (perf_wr_cnt[63:32] !== 32'd10) begin bad++; $display("FAIL perf_wr1 got=%0d exp=10", perf_wr_cnt[63:32]); end
        total++; if (perf_wr_cnt[31:0] !== 32'd0) begin bad++; $display("FAIL perf_wr0 got=%0d exp=0", perf_wr_cnt[31:0]); end
        total++; if (perf_stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", perf_stall_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        clear_reqs();
        test_reset();
        test_round_robin();
        test_hilo();
        test_collision();
        test_zero_flush();
`ifdef WB_ARB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
